imuldiv_div_requester: RTL and testbench

//  Issuing end of the divider val/rdy protocol. Takes divide ops from the

---
 rtl/imuldiv_div_requester_pkg.sv | 18 +
 rtl/imuldiv_div_requester_tagq.sv | 55 +++++
 rtl/imuldiv_div_requester.sv | 100 ++++++++++
 tb/tb_imuldiv_div_requester.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_requester_pkg.sv
// Shared constants for the divider requester: divreq function encodings and
// the layout of the 64-bit divresp result word.
package imuldiv_div_requester_pkg;

    localparam logic FUNC_SIGNED   = 1'b0;
    localparam logic FUNC_UNSIGNED = 1'b1;

    localparam int WORD_W   = 32;
    localparam int QUOT_LSB = 0;
    localparam int REM_LSB  = 32;

    // Picks the remainder or quotient half of a divider response.
    function automatic logic [WORD_W-1:0] sel_result(input logic [2*WORD_W-1:0] result,
                                                      input logic                sel_rem);
        return sel_rem ? result[REM_LSB +: WORD_W] : result[QUOT_LSB +: WORD_W];
    endfunction

endpackage

// File: rtl/imuldiv_div_requester_tagq.sv
// Circular tag FIFO for in-flight divide ops; occupancy kept in an explicit
// count so full and empty never depend on pointer equality.
module imuldiv_DivTagQueue #(
    parameter  int DEPTH = 4,
    parameter  int W     = 6,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_div_requester.sv
// Issuing end of the divider val/rdy protocol: gates op issue on in-flight
// count and returns quotient or remainder with its tag through one output register.
module imuldiv_div_requester
    import imuldiv_div_requester_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int DEST_W          = 5,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_val,
    output logic              op_rdy,
    input  logic              op_fn,
    input  logic              op_sel_rem,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic [DEST_W-1:0] op_dest,
    output logic              divreq_msg_fn,
    output logic [31:0]       divreq_msg_a,
    output logic [31:0]       divreq_msg_b,
    output logic              divreq_val,
    input  logic              divreq_rdy,
    input  logic [63:0]       divresp_msg_result,
    input  logic              divresp_val,
    output logic              divresp_rdy,
    output logic              wb_val,
    input  logic              wb_rdy,
    output logic [31:0]       wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_spurious
);

    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_resp_fire;
    logic              w_pop;
    logic [DEST_W:0]   w_tag;
    logic              r_wb_val;
    logic [31:0]       r_wb_data;
    logic [DEST_W-1:0] r_wb_dest;
    logic              r_err;

    assign divreq_msg_fn = op_fn;
    assign divreq_msg_a  = op_a;
    assign divreq_msg_b  = op_b;
    // Full blocks issue even if a pop happens this cycle: no same-cycle bypass.
    assign divreq_val    = op_val & ~w_full;
    assign op_rdy        = divreq_rdy & ~w_full;
    assign w_issue       = op_val & op_rdy;

    assign divresp_rdy   = ~r_wb_val | wb_rdy;
    assign w_resp_fire   = divresp_val & divresp_rdy;
    assign w_pop         = w_resp_fire & ~w_empty;

    imuldiv_DivTagQueue #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (DEST_W + 1)
    ) u_tagq (
        .clk   (clk),
        .reset (reset),
        .push  (w_issue),
        .wdata ({op_sel_rem, op_dest}),
        .pop   (w_pop),
        .rdata (w_tag),
        .full  (w_full),
        .empty (w_empty),
        .count (outstanding)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_val  <= 1'b0;
            r_wb_data <= '0;
            r_wb_dest <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_resp_fire) begin
                // A spurious response is accepted but produces no writeback.
                r_wb_val <= w_pop;
                if (w_pop) begin
                    r_wb_data <= sel_result(divresp_msg_result, w_tag[DEST_W]);
                    r_wb_dest <= w_tag[DEST_W-1:0];
                end else begin
                    r_err <= 1'b1;
                end
            end else if (wb_rdy) begin
                r_wb_val <= 1'b0;
            end
        end
    end

    assign wb_val       = r_wb_val;
    assign wb_data      = r_wb_data;
    assign wb_dest      = r_wb_dest;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Randomized and directed bench for imuldiv_div_requester against a queue-based
// behavioural model with an arithmetic divider stand-in.
module tb_imuldiv_div_requester;
    import imuldiv_div_requester_pkg::*;

    localparam int MAXO = 4;

    logic        clk = 0, reset = 0;
    logic        op_val = 0, op_rdy, op_fn = 0, op_sel_rem = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic [4:0]  op_dest = 0;
    logic        divreq_msg_fn, divreq_val, divreq_rdy = 0;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic [63:0] divresp_msg_result = 0;
    logic        divresp_val = 0, divresp_rdy;
    logic        wb_val, wb_rdy = 0;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic [2:0]  outstanding;
    logic        err_spurious;

    imuldiv_div_requester #(.MAX_OUTSTANDING(MAXO), .DEST_W(5)) dut (
        .clk(clk), .reset(reset), .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn),
        .op_sel_rem(op_sel_rem), .op_a(op_a), .op_b(op_b), .op_dest(op_dest),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divresp_msg_result(divresp_msg_result),
        .divresp_val(divresp_val), .divresp_rdy(divresp_rdy), .wb_val(wb_val), .wb_rdy(wb_rdy),
        .wb_data(wb_data), .wb_dest(wb_dest), .outstanding(outstanding), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] golden(input logic fn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (fn == FUNC_SIGNED) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'b0, a});
            lb = longint'({32'b0, b});
        end
        if (lb == 0) begin q = -1; r = la; end
        else begin q = la / lb; r = la % lb; end
        return {r[31:0], q[31:0]};
    endfunction

    // Model: tags in flight, divider results in flight, the writeback slot, sticky error.
    typedef struct packed { logic sel; logic [4:0] dest; } mtag_t;
    mtag_t       mq[$];
    logic [63:0] divq[$];
    bit          m_wbv = 0, m_err = 0, m_iss = 0;
    logic [31:0] m_wbd = 0;
    logic [4:0]  m_wbt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete(); divq.delete();
            m_wbv = 0; m_wbd = 0; m_wbt = 0; m_err = 0; m_iss = 0;
        end else begin
            mtag_t t;
            bit rfire;
            m_iss = op_val && divreq_rdy && (mq.size() < MAXO);
            rfire = divresp_val && (!m_wbv || wb_rdy);
            if (rfire) begin
                if (divq.size() > 0) void'(divq.pop_front());
                if (mq.size() > 0) begin
                    t = mq.pop_front();
                    m_wbv = 1;
                    m_wbd = t.sel ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
                    m_wbt = t.dest;
                end else begin
                    m_err = 1;
                    m_wbv = 0;
                end
            end else if (m_wbv && wb_rdy) begin
                m_wbv = 0;
            end
            if (m_iss) begin
                t.sel = op_sel_rem; t.dest = op_dest;
                mq.push_back(t);
                divq.push_back(golden(op_fn, op_a, op_b));
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) if (cmp_en) begin
        chk("op_rdy",      op_rdy,      divreq_rdy && (mq.size() < MAXO));
        chk("divreq_val",  divreq_val,  op_val && (mq.size() < MAXO));
        chk("divreq_msg",  {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {op_fn, op_a, op_b});
        chk("divresp_rdy", divresp_rdy, !m_wbv || wb_rdy);
        chk("wb_val",      wb_val,      m_wbv);
        chk("wb_data",     wb_data,     m_wbd);
        chk("wb_dest",     wb_dest,     m_wbt);
        chk("outstanding", outstanding, mq.size());
        chk("err",         err_spurious, m_err);
    end

    // Environment knobs: divider ready/response rates, writeback ready rate.
    int p_dreq = 100, p_resp = 100, p_wbr = 100;
    bit resp_en = 1, spur = 0, rand_ops = 0;

    task automatic drive_env();
        divreq_rdy = ($urandom_range(99) < p_dreq);
        wb_rdy     = ($urandom_range(99) < p_wbr);
        if (spur) begin
            divresp_val = 1; divresp_msg_result = 64'hDEADBEEF_0BADF00D;
        end else if (resp_en && divq.size() > 0 && $urandom_range(99) < p_resp) begin
            divresp_val = 1; divresp_msg_result = divq[0];
        end else begin
            divresp_val = 0; divresp_msg_result = {$urandom, $urandom};
        end
        if (rand_ops) begin
            op_val = $urandom_range(1); op_fn = $urandom_range(1); op_sel_rem = $urandom_range(1);
            op_a = $urandom; op_dest = $urandom_range(31);
            op_b = ($urandom_range(7) == 0) ? 32'd0 : ($urandom_range(1) ? $urandom : $urandom_range(20));
        end
    endtask

    task automatic step();
        @(posedge clk); #1; drive_env();
    endtask

    task automatic issue_op(input logic fn, input logic [31:0] a, input logic [31:0] b,
                            input logic sel, input logic [4:0] dest);
        op_fn = fn; op_a = a; op_b = b; op_sel_rem = sel; op_dest = dest; op_val = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_iss) begin op_val = 0; return; end
        end
        op_val = 0;
        chk("issue_timeout", 0, 1);
    endtask

    logic [4:0]  got_t [3];
    logic [31:0] got_d [3];
    int k;

    initial begin
        step(); step();
        reset = 1;
        step();
        cmp_en = 1;

        // Single signed op, quotient then remainder
        issue_op(FUNC_SIGNED, -32'sd7, 32'd2, 1'b0, 5'd3);
        step();
        chk("t2_wb_val", wb_val, 1); chk("t2_quot", wb_data, 32'hFFFFFFFD); chk("t2_dest", wb_dest, 3);
        step();
        issue_op(FUNC_SIGNED, -32'sd7, 32'd2, 1'b1, 5'd3);
        step();
        chk("t2_rem", wb_data, 32'hFFFFFFFF); chk("t2_rem_dest", wb_dest, 3);
        step(); step();

        // Fill with responses stalled
        resp_en = 0;
        for (int i = 0; i < 4; i++) issue_op(FUNC_UNSIGNED, 32'd100 + i, 32'd3, 1'b0, 5'(10 + i));
        op_fn = FUNC_UNSIGNED; op_a = 32'd555; op_b = 32'd5; op_sel_rem = 0; op_dest = 5'd14; op_val = 1;
        step(); step();
        chk("t3_op_rdy_full", op_rdy, 0); chk("t3_outstanding4", outstanding, 4);
        resp_en = 1; step(); resp_en = 0; step();
        chk("t3_outstanding3", outstanding, 3);
        step();
        chk("t3_fifth_issued", outstanding, 4);
        op_val = 0; resp_en = 1;
        repeat (10) step();

        // Writeback backpressure with three pending results
        resp_en = 0;
        issue_op(FUNC_UNSIGNED, 32'd100, 32'd7, 1'b0, 5'd1);
        issue_op(FUNC_UNSIGNED, 32'd1000, 32'd33, 1'b0, 5'd2);
        issue_op(FUNC_SIGNED, -32'sd50, 32'd6, 1'b0, 5'd3);
        p_wbr = 0; wb_rdy = 0; resp_en = 1;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_resp_rdy", divresp_rdy, 0); chk("t4_stable_dest", wb_dest, 1);
            chk("t4_stable_data", wb_data, 32'hE);
        end
        p_wbr = 100; wb_rdy = 1; k = 0;
        for (int i = 0; i < 10; i++) begin
            if (wb_val && wb_rdy && k < 3) begin got_t[k] = wb_dest; got_d[k] = wb_data; k++; end
            step();
        end
        chk("t4_drained", k, 3);
        chk("t4_d1", {got_t[0], got_d[0]}, {5'd1, 32'h0000000E});
        chk("t4_d2", {got_t[1], got_d[1]}, {5'd2, 32'h0000001E});
        chk("t4_d3", {got_t[2], got_d[2]}, {5'd3, 32'hFFFFFFF8});

        // Issue and pop together at outstanding 2, across pointer wrap
        resp_en = 0;
        issue_op(FUNC_UNSIGNED, 32'd77, 32'd5, 1'b1, 5'd20);
        issue_op(FUNC_UNSIGNED, 32'd78, 32'd5, 1'b0, 5'd21);
        resp_en = 1; step();
        for (int i = 0; i < 12; i++) begin
            op_val = 1; op_fn = $urandom_range(1); op_a = $urandom; op_b = $urandom_range(1, 99);
            op_sel_rem = $urandom_range(1); op_dest = 5'(i);
            step();
            chk("t5_steady2", outstanding, 2);
        end
        op_val = 0;
        repeat (8) step();

        // Randomized traffic
        rand_ops = 1;
        for (int r = 0; r < 15; r++) begin
            p_dreq = $urandom_range(30, 100); p_resp = $urandom_range(20, 100); p_wbr = $urandom_range(20, 100);
            repeat (200) step();
        end
        rand_ops = 0; op_val = 0; p_dreq = 100; p_resp = 100; p_wbr = 100;
        repeat (20) step();
        chk("drained_empty", outstanding, 0);

        // Spurious response
        spur = 1; step(); spur = 0; step();
        chk("t6_err", err_spurious, 1); chk("t6_no_wb", wb_val, 0);
        issue_op(FUNC_UNSIGNED, 32'd9, 32'd3, 1'b0, 5'd7);
        repeat (4) step();
        chk("t6_sticky", err_spurious, 1);

        // Asynchronous reset mid-traffic with two ops in flight
        resp_en = 0;
        issue_op(FUNC_UNSIGNED, 32'd40, 32'd6, 1'b1, 5'd9);
        issue_op(FUNC_UNSIGNED, 32'd41, 32'd6, 1'b1, 5'd10);
        @(posedge clk); #3; reset = 0; #1;
        chk("t1_out0", outstanding, 0); chk("t1_wbv0", wb_val, 0); chk("t1_wbd0", wb_data, 0);
        chk("t1_wbt0", wb_dest, 0); chk("t1_err0", err_spurious, 0);
        step(); reset = 1; resp_en = 1; step();
        chk("t1_out_after", outstanding, 0); chk("t1_op_rdy", op_rdy, divreq_rdy);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
